// File: rtl/tx_phy_pkg.sv
// Shared definitions for the multi-lane transmit PHY: FSM states, line levels
// and a width helper.
package tx_phy_pkg;

    typedef enum logic [1:0] {
        EIDLE  = 2'd0,
        DETECT = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // Both legs low in electrical idle, both high for the detect common-mode step.
    localparam logic EIDLE_LINE  = 1'b0;
    localparam logic DETECT_LINE = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tx_lane_serializer.sv
// One serial lane: LSB-first shift register, lane-enable flop and the
// differential line driver.
module tx_lane_serializer
    import tx_phy_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] sym,
    input  logic             shift,
    input  logic             en_load,
    input  logic             en_in,
    input  logic             active,
    input  logic             detect,
    output logic             tx_p,
    output logic             tx_n
);

    logic [WIDTH-1:0] shreg;
    logic             en;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            en    <= 1'b0;
        end else begin
            if (load) begin
                shreg <= sym;
            end else if (shift) begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
            if (en_load) en <= en_in;
        end
    end

    // NOTE: both outputs get a default before any branch so no latch is inferred.
    always_comb begin
        tx_p = EIDLE_LINE;
        tx_n = EIDLE_LINE;
        if (detect) begin
            tx_p = DETECT_LINE;
            tx_n = DETECT_LINE;
        end else if (active && en) begin
            tx_p = shreg[0];
            tx_n = ~shreg[0];
        end
    end

endmodule

// File: rtl/tx_phy_multilane.sv
// Multi-lane transmit PHY: lockstep word serialisation, word-aligned electrical
// idle and a timed receiver-detect sequence.
module tx_phy_multilane
    import tx_phy_pkg::*;
#(
    parameter int               LANES      = 4,
    parameter int               WIDTH      = 8,
    parameter int               DET_CYCLES = 16,
    parameter logic [WIDTH-1:0] FILL_SYM   = '0
) (
    input  logic                   TRANSCLK,
    input  logic                   RESET,
    input  logic [LANES*WIDTH-1:0] TXDATA,
    input  logic                   TXVALID,
    output logic                   TXREADY,
    input  logic                   TXIDLE,
    input  logic [LANES-1:0]       LANE_EN,
    input  logic                   RXDET,
    input  logic [LANES-1:0]       RXDET_SENSE,
    output logic                   RXDET_O,
    output logic [LANES-1:0]       RXDET_STATUS,
    output logic [LANES-1:0]       TX_P,
    output logic [LANES-1:0]       TX_N
);

    localparam int             BW       = clog2(WIDTH);
    localparam int             DW       = clog2(DET_CYCLES);
    localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0]  DET_LAST = DW'(DET_CYCLES - 1);

    state_t                   state, state_nxt;
    logic [BW-1:0]            bit_cnt;
    logic [DW-1:0]            det_cnt;
    logic                     is_active, is_detect;
    logic                     load_slot, det_last, start;
    logic [LANES*WIDTH-1:0]   load_data;

    assign is_active = (state == ACTIVE);
    assign is_detect = (state == DETECT);
    assign det_last  = is_detect && (det_cnt == DET_LAST);
    // A detect request in EIDLE takes the slot away from the link layer.
    assign load_slot = ((state == EIDLE) && !RXDET) || (is_active && (bit_cnt == BIT_LAST));
    assign TXREADY   = load_slot && !TXIDLE;
    assign start     = (state == EIDLE) && TXREADY;
    assign load_data = TXVALID ? TXDATA : {LANES{FILL_SYM}};
    assign RXDET_O   = det_last;

    always_comb begin
        state_nxt = state;
        case (state)
            EIDLE: begin
                if (RXDET)        state_nxt = DETECT;
                else if (!TXIDLE) state_nxt = ACTIVE;
            end
            DETECT: if (det_last) state_nxt = EIDLE;
            ACTIVE: if (load_slot && TXIDLE) state_nxt = EIDLE;
            default: state_nxt = EIDLE;
        endcase
    end

    always_ff @(posedge TRANSCLK) begin
        if (RESET) begin
            state        <= EIDLE;
            bit_cnt      <= '0;
            det_cnt      <= '0;
            RXDET_STATUS <= '0;
        end else begin
            state <= state_nxt;
            if (is_active) begin
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end else begin
                bit_cnt <= '0;
            end
            if (is_detect && !det_last) begin
                det_cnt <= det_cnt + 1'b1;
            end else begin
                det_cnt <= '0;
            end
            if (det_last) RXDET_STATUS <= RXDET_SENSE;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        tx_lane_serializer #(.WIDTH(WIDTH)) u_lane (
            .clk     (TRANSCLK),
            .rst     (RESET),
            .load    (TXREADY),
            .sym     (load_data[l*WIDTH +: WIDTH]),
            .shift   (is_active),
            .en_load (start),
            .en_in   (LANE_EN[l]),
            .active  (is_active),
            .detect  (is_detect),
            .tx_p    (TX_P[l]),
            .tx_n    (TX_N[l])
        );
    end

endmodule

// File: tb/tb_tx_phy_multilane.sv
// Directed self-checking bench for tx_phy_multilane (4 lanes x 8 bits, 16-cycle detect).
module tb_tx_phy_multilane;

    localparam logic [31:0] W0 = 32'hA5_3C_0F_81;
    localparam logic [31:0] W1 = 32'h12_34_56_78;
    localparam logic [31:0] W2 = 32'hDE_AD_BE_EF;
    localparam logic [31:0] W3 = 32'h0F_1E_2D_3C;
    localparam logic [31:0] W4 = 32'h66_99_CC_33;
    localparam logic [31:0] W5 = 32'hFF_77_A5_5A;
    localparam logic [31:0] W6 = 32'h80_01_7F_FE;
    localparam logic [31:0] W7 = 32'hC3_96_E1_4B;

    logic        TRANSCLK;
    logic        RESET;
    logic [31:0] TXDATA;
    logic        TXVALID;
    logic        TXREADY;
    logic        TXIDLE;
    logic [3:0]  LANE_EN;
    logic        RXDET;
    logic [3:0]  RXDET_SENSE;
    logic        RXDET_O;
    logic [3:0]  RXDET_STATUS;
    logic [3:0]  TX_P;
    logic [3:0]  TX_N;

    int n_tests = 0;
    int n_fail  = 0;

    tx_phy_multilane #(
        .LANES(4), .WIDTH(8), .DET_CYCLES(16), .FILL_SYM(8'h00)
    ) dut (
        .TRANSCLK     (TRANSCLK),
        .RESET        (RESET),
        .TXDATA       (TXDATA),
        .TXVALID      (TXVALID),
        .TXREADY      (TXREADY),
        .TXIDLE       (TXIDLE),
        .LANE_EN      (LANE_EN),
        .RXDET        (RXDET),
        .RXDET_SENSE  (RXDET_SENSE),
        .RXDET_O      (RXDET_O),
        .RXDET_STATUS (RXDET_STATUS),
        .TX_P         (TX_P),
        .TX_N         (TX_N)
    );

    initial TRANSCLK = 1'b0;
    always #5 TRANSCLK = ~TRANSCLK;

    // Bit i of every lane's symbol, lane l in bit l.
    function automatic logic [3:0] lane_bits(input logic [31:0] w, input int i);
        logic [3:0] r;
        for (int l = 0; l < 4; l++) r[l] = w[l*8 + i];
        return r;
    endfunction

    task automatic test_reset();
        RESET = 1'b1; TXIDLE = 1'b1; RXDET = 1'b0; TXVALID = 1'b0;
        TXDATA = '0; LANE_EN = '0; RXDET_SENSE = '0;
        repeat (3) @(negedge TRANSCLK);
        RESET = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge TRANSCLK); #1;
            n_tests++;
            if (TX_P !== 4'h0 || TX_N !== 4'h0 || TXREADY !== 1'b0 || RXDET_O !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d: P=%b N=%b rdy=%b det_o=%b, expected 0000 0000 0 0",
                         c, TX_P, TX_N, TXREADY, RXDET_O);
            end
        end
        n_tests++;
        if (RXDET_STATUS !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_status: got %b expected 0000", RXDET_STATUS);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] lane0 = 8'b1000_0001;
        @(negedge TRANSCLK);
        TXIDLE = 1'b0; LANE_EN = 4'hF; TXVALID = 1'b1; TXDATA = W0;
        #1;
        n_tests++;
        if (TXREADY !== 1'b1 || TX_P !== 4'h0) begin
            n_fail++;
            $display("FAIL single_accept: rdy=%b P=%b expected 1 0000", TXREADY, TX_P);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge TRANSCLK);
            if (i == 0) TXVALID = 1'b0;
            if (i == 7) begin TXVALID = 1'b1; TXDATA = W1; end
            #1;
            n_tests++;
            if (TX_P !== lane_bits(W0, i) || TX_N !== ~lane_bits(W0, i)) begin
                n_fail++;
                $display("FAIL single_bits i=%0d: P=%b N=%b expected P=%b N=%b",
                         i, TX_P, TX_N, lane_bits(W0, i), ~lane_bits(W0, i));
            end
            n_tests++;
            if (TX_P[0] !== lane0[i]) begin
                n_fail++;
                $display("FAIL single_lane0 i=%0d: got %b expected %b", i, TX_P[0], lane0[i]);
            end
            n_tests++;
            if (TXREADY !== (i == 7)) begin
                n_fail++;
                $display("FAIL single_ready i=%0d: got %b expected %b", i, TXREADY, (i == 7));
            end
        end
    endtask

    // W1 already accepted; W2, W3 follow, then one slot with TXVALID low (fill).
    task automatic test_back_to_back();
        logic [31:0] seq [4] = '{W1, W2, W3, 32'h0};
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge TRANSCLK);
                if (i == 7) begin
                    case (k)
                        0: TXDATA = W2;
                        1: TXDATA = W3;
                        2: TXVALID = 1'b0;
                        default: begin TXVALID = 1'b1; TXDATA = W4; end
                    endcase
                end
                #1;
                n_tests++;
                if (TX_P !== lane_bits(seq[k], i) || TX_N !== ~lane_bits(seq[k], i)) begin
                    n_fail++;
                    $display("FAIL b2b_bits k=%0d i=%0d: P=%b N=%b expected P=%b N=%b",
                             k, i, TX_P, TX_N, lane_bits(seq[k], i), ~lane_bits(seq[k], i));
                end
                n_tests++;
                if (TXREADY !== (i == 7)) begin
                    n_fail++;
                    $display("FAIL b2b_ready k=%0d i=%0d: got %b expected %b", k, i, TXREADY, (i == 7));
                end
            end
        end
    endtask

    // W4 in flight; TXIDLE rises at bit 3, the word still completes.
    task automatic test_idle_entry();
        for (int i = 0; i < 8; i++) begin
            @(negedge TRANSCLK);
            if (i == 3) TXIDLE = 1'b1;
            if (i == 7) TXDATA = W5;
            #1;
            n_tests++;
            if (TX_P !== lane_bits(W4, i) || TX_N !== ~lane_bits(W4, i) || TXREADY !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_word i=%0d: P=%b N=%b rdy=%b expected P=%b N=%b rdy=0",
                         i, TX_P, TX_N, TXREADY, lane_bits(W4, i), ~lane_bits(W4, i));
            end
        end
        TXVALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge TRANSCLK); #1;
            n_tests++;
            if (TX_P !== 4'h0 || TX_N !== 4'h0 || TXREADY !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_lines c=%0d: P=%b N=%b rdy=%b expected 0000 0000 0",
                         c, TX_P, TX_N, TXREADY);
            end
        end
    endtask

    task automatic test_rxdet();
        @(negedge TRANSCLK);
        RXDET = 1'b1; RXDET_SENSE = 4'b1010; TXIDLE = 1'b0; TXVALID = 1'b1;
        #1;
        n_tests++;
        if (TXREADY !== 1'b0 || TX_P !== 4'h0) begin
            n_fail++;
            $display("FAIL det_priority: rdy=%b P=%b expected 0 0000", TXREADY, TX_P);
        end
        for (int d = 1; d <= 16; d++) begin
            @(negedge TRANSCLK);
            RXDET = (d == 5);
            #1;
            n_tests++;
            if (TX_P !== 4'hF || TX_N !== 4'hF || TXREADY !== 1'b0 || RXDET_O !== (d == 16)) begin
                n_fail++;
                $display("FAIL det_run d=%0d: P=%b N=%b rdy=%b det_o=%b expected 1111 1111 0 %b",
                         d, TX_P, TX_N, TXREADY, RXDET_O, (d == 16));
            end
        end
        @(negedge TRANSCLK);
        RXDET_SENSE = 4'b0000; TXIDLE = 1'b1; TXVALID = 1'b0;
        #1;
        n_tests++;
        if (TX_P !== 4'h0 || TX_N !== 4'h0 || RXDET_O !== 1'b0 || RXDET_STATUS !== 4'b1010) begin
            n_fail++;
            $display("FAIL det_done: P=%b N=%b det_o=%b status=%b expected 0000 0000 0 1010",
                     TX_P, TX_N, RXDET_O, RXDET_STATUS);
        end
    endtask

    task automatic test_lane_mask();
        @(negedge TRANSCLK);
        TXIDLE = 1'b0; LANE_EN = 4'b0011; TXVALID = 1'b1; TXDATA = W5;
        #1;
        n_tests++;
        if (TXREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_accept: got %b expected 1", TXREADY);
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge TRANSCLK);
                if (k == 0 && i == 2) LANE_EN = 4'b1111;
                if (i == 7) begin
                    if (k == 0) TXDATA = W6;
                    else begin TXIDLE = 1'b1; TXVALID = 1'b0; end
                end
                #1;
                n_tests++;
                if (TX_P !== (lane_bits(k ? W6 : W5, i) & 4'b0011) ||
                    TX_N !== (~lane_bits(k ? W6 : W5, i) & 4'b0011) ||
                    TXREADY !== (i == 7 && k == 0)) begin
                    n_fail++;
                    $display("FAIL mask_narrow k=%0d i=%0d: P=%b N=%b rdy=%b expected P=%b N=%b rdy=%b",
                             k, i, TX_P, TX_N, TXREADY, lane_bits(k ? W6 : W5, i) & 4'b0011,
                             ~lane_bits(k ? W6 : W5, i) & 4'b0011, (i == 7 && k == 0));
                end
            end
        end
        @(negedge TRANSCLK); #1;
        n_tests++;
        if (TX_P !== 4'h0 || TX_N !== 4'h0) begin
            n_fail++;
            $display("FAIL mask_gap: P=%b N=%b expected 0000 0000", TX_P, TX_N);
        end
        @(negedge TRANSCLK);
        TXIDLE = 1'b0; TXVALID = 1'b1; TXDATA = W7;
        #1;
        for (int i = 0; i < 8; i++) begin
            @(negedge TRANSCLK);
            if (i == 7) begin TXIDLE = 1'b1; TXVALID = 1'b0; end
            #1;
            n_tests++;
            if (TX_P !== lane_bits(W7, i) || TX_N !== ~lane_bits(W7, i)) begin
                n_fail++;
                $display("FAIL mask_wide i=%0d: P=%b N=%b expected P=%b N=%b",
                         i, TX_P, TX_N, lane_bits(W7, i), ~lane_bits(W7, i));
            end
        end
        @(negedge TRANSCLK); #1;
        n_tests++;
        if (TX_P !== 4'h0 || TX_N !== 4'h0 || TXREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_end: P=%b N=%b rdy=%b expected 0000 0000 0", TX_P, TX_N, TXREADY);
        end
    endtask

    task automatic test_reset_mid_detect();
        @(negedge TRANSCLK);
        RXDET = 1'b1; RXDET_SENSE = 4'b0101;
        #1;
        for (int d = 1; d <= 6; d++) begin
            @(negedge TRANSCLK);
            RXDET = 1'b0;
            if (d == 6) RESET = 1'b1;
            #1;
            n_tests++;
            if (TX_P !== 4'hF || TX_N !== 4'hF || RXDET_O !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_run d=%0d: P=%b N=%b det_o=%b expected 1111 1111 0",
                         d, TX_P, TX_N, RXDET_O);
            end
        end
        @(negedge TRANSCLK); #1;
        n_tests++;
        if (TX_P !== 4'h0 || TX_N !== 4'h0 || RXDET_O !== 1'b0 ||
            RXDET_STATUS !== 4'h0 || TXREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: P=%b N=%b det_o=%b status=%b rdy=%b expected 0000 0000 0 0000 0",
                     TX_P, TX_N, RXDET_O, RXDET_STATUS, TXREADY);
        end
        @(negedge TRANSCLK);
        RESET = 1'b0;
        #1;
        for (int c = 0; c < 20; c++) begin
            @(negedge TRANSCLK); #1;
            n_tests++;
            if (RXDET_O !== 1'b0 || TX_P !== 4'h0 || RXDET_STATUS !== 4'h0) begin
                n_fail++;
                $display("FAIL abort_after c=%0d: det_o=%b P=%b status=%b expected 0 0000 0000",
                         c, RXDET_O, TX_P, RXDET_STATUS);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_idle_entry();
        test_rxdet();
        test_lane_mask();
        test_reset_mid_detect();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_phy_multilane.md
Name: tx_phy_multilane

Overview:
Parametrised multi-lane transmit PHY. It is the successor to the single-lane, bit-at-a-time TX I/O block.
- Accepts one WIDTH-bit symbol per lane through a valid/ready handshake and serialises all lanes in lockstep, LSB first, onto TX_P/TX_N differential pairs.
- Supports per-lane enable, electrical idle entered and left on word boundaries, and a timed receiver-detect sequence that reports presence per lane.
- Sits between the link layer and the pads; it drives the existing RX I/O receivers lane by lane.

Parameters:
LANES, 4, number of serial lanes.
WIDTH, 8, symbol width per lane, in bits (≥2).
DET_CYCLES, 16, length of the receiver-detect sequence, in TRANSCLK cycles (≥2).
FILL_SYM, 0, WIDTH-bit symbol loaded when a load slot has TXVALID=0.

Ports:
TRANSCLK  in  1  sole clock; all logic is rising-edge.
RESET  in  1  synchronous, active-high reset.
TXDATA  in  LANES*WIDTH  lane l occupies bits [l*WIDTH +: WIDTH].
TXVALID  in  1  TXDATA valid.
TXREADY  out  1  word accepted this cycle when TXVALID=1 (combinational).
TXIDLE  in  1  request electrical idle.
LANE_EN  in  LANES  lane enable mask.
RXDET  in  1  receiver-detect request.
RXDET_SENSE  in  LANES  far-end termination sense from the pad.
RXDET_O  out  1  one-cycle pulse: detect finished.
RXDET_STATUS  out  LANES  per-lane detect result.
TX_P  out  LANES  positive line.
TX_N  out  LANES  negative line.

Behaviour:
- One clock (TRANSCLK). Reset is synchronous and active-high (RESET).
- Reset values: state=EIDLE, bit_cnt=0, all shift registers 0, TX_P=TX_N=0, RXDET_O=0, RXDET_STATUS=0, latched lane mask=0.
- RESET asserted mid-word or mid-detect aborts the operation. The in-flight word is lost and no RXDET_O pulse is generated.
- FSM states: EIDLE, DETECT, ACTIVE.
- EIDLE:
  - TX_P=TX_N=0 on all lanes.
  - If RXDET=1, go to DETECT; RXDET has priority over TXIDLE.
  - Otherwise, if TXIDLE=0, this cycle is a load slot. Latch LANE_EN and go to ACTIVE.
- DETECT:
  - Runs exactly DET_CYCLES cycles with TX_P=TX_N=1 on all lanes (common-mode step).
  - On the final cycle, register RXDET_SENSE into RXDET_STATUS and pulse RXDET_O for one cycle. The next state is EIDLE.
  - RXDET, TXIDLE and TXVALID are ignored while in DETECT.
- ACTIVE:
  - Each cycle, every enabled lane drives TX_P=shreg[0] and TX_N=~TX_P, shifts right, and increments bit_cnt.
  - The cycle with bit_cnt==WIDTH-1 is a load slot.
  - Disabled lanes hold TX_P=TX_N=0.
- Load slot rules:
  - TXREADY = load_slot & ~TXIDLE.
  - If TXREADY & TXVALID, load TXDATA. If TXREADY & ~TXVALID, load FILL_SYM on every lane; no handshake occurs.
  - If TXIDLE=1 at a load slot in ACTIVE, nothing is loaded and the next state is EIDLE. Idle entry is therefore word-aligned, and the last word always completes.
- Latency: a word accepted in cycle k drives bit 0 in cycle k+1 and bit WIDTH-1 in cycle k+WIDTH. Back-to-back words leave no gap bits.
- RXDET in ACTIVE is ignored; detection is legal only from EIDLE.
- TXIDLE outside a load slot has no effect until the next load slot.
- LANE_EN is sampled only on EIDLE→ACTIVE. Mid-word changes have no effect.
- bit_cnt wraps from WIDTH-1 to 0. Its width is clog2(WIDTH); the detect counter width is clog2(DET_CYCLES).

Decomposition:
- Shared package tx_phy_pkg holds:
  - the state enum (EIDLE, DETECT, ACTIVE);
  - electrical-idle and detect line-level constants;
  - the clog2 helper function.
- Sub-module tx_lane_serializer holds one lane's shift register, enable flop and differential driver. It is instantiated LANES times by generate.
- FSM, counters and handshake stay in the top level.

Test Plan:
1. Reset hold, then release with TXIDLE=1 and RXDET=0 → TX_P=TX_N=0 on all lanes, TXREADY=0, RXDET_O=0 for 20 cycles.
2. TXIDLE→0, LANE_EN=4'b1111, TXVALID=1, TXDATA=32'hA5_3C_0F_81 → TXREADY high in the first cycle. Lane0 TX_P serialises 1,0,0,0,0,0,0,1 over the next 8 cycles, with TX_N its complement. The next TXREADY comes 8 cycles later.
3. Stream 3 words back-to-back, then drop TXVALID for one load slot → no gap bits between words, and FILL_SYM 0x00 is seen on all lanes for 8 cycles.
4. Raise TXIDLE mid-word (bit 3) → the word finishes all 8 bits, TXREADY stays 0 at that load slot, then TX_P=TX_N=0.
5. From EIDLE, pulse RXDET with RXDET_SENSE=4'b1010 → TX_P=TX_N=1 for 16 cycles. RXDET_O pulses on the 16th cycle, RXDET_STATUS=4'b1010, then the block returns to EIDLE. A second RXDET pulse during DETECT is ignored.
6. LANE_EN=4'b0011 on idle exit, then change it to 4'b1111 mid-stream → lanes 2–3 stay at P=N=0 until the next EIDLE→ACTIVE. Separately, assert RESET mid-detect → no RXDET_O pulse, and all outputs return to their reset values the next cycle.
